// File: rtl/qarma64_sched_if.sv
// Request/response bundle between the requesters and the Qarma64 scheduler.
// The scheduler takes the slave modport; the requester side takes the master modport.
`timescale 1ns/1ps
interface qarma64_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [64*N_REQ-1:0]  req_in;
  logic [64*N_REQ-1:0]  req_tweak;
  logic [128*N_REQ-1:0] req_key;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic [63:0]          resp_data;
  logic                 resp_err;

  modport master (
    output req_valid, req_in, req_tweak, req_key, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_in, req_tweak, req_key, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/qarma64_sched.sv
// Round-robin scheduler sharing one Qarma64 core between N_REQ requesters.
// Launches the core through its active-low load, waits for ready, returns a tagged response.
`timescale 1ns/1ps
module qarma64_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           reset,
  qarma64_sched_if.slave bus,
  output logic           busy,
  output logic [15:0]    op_count,
  output logic [63:0]    core_in,
  output logic [63:0]    core_tweak,
  output logic [127:0]   core_key,
  output logic           core_load_n,
  input  logic [63:0]    core_out,
  input  logic           core_ready
);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt;
  logic [ID_W-1:0] grant_id, hi_id, lo_id;
  logic            grant_vld, hi_vld, lo_vld;
  logic [CNT_W-1:0] wait_cnt;
  logic            wait_expire;
  logic [63:0]     sel_in, sel_tweak;
  logic [127:0]    sel_key;

  // Lowest valid index at or above ptr wins; otherwise the lowest below ptr.
  always_comb begin : arbiter
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (ID_W'(i) >= ptr) begin
          hi_vld = 1'b1;
          hi_id  = ID_W'(i);
        end else begin
          lo_vld = 1'b1;
          lo_id  = ID_W'(i);
        end
      end
    end
    grant_vld = hi_vld | lo_vld;
    grant_id  = hi_vld ? hi_id : lo_id;
  end

  assign ptr_nxt = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_comb begin : operand_mux
    sel_in    = '0;
    sel_tweak = '0;
    sel_key   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_in    = bus.req_in[64*i +: 64];
        sel_tweak = bus.req_tweak[64*i +: 64];
        sel_key   = bus.req_key[128*i +: 128];
      end
    end
  end

  always_comb begin : accept_pulse
    bus.req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_ready[i] = (state == S_IDLE) && grant_vld && (grant_id == ID_W'(i));
    end
  end

  assign wait_expire = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign busy        = (state != S_IDLE);

  always_comb begin : fsm_next
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (grant_vld) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_WAIT;
      S_WAIT:  if (core_ready || wait_expire) state_nxt = S_RESP;
      S_RESP:  if (bus.resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr            <= '0;
      wait_cnt       <= '0;
      op_count       <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= '0;
      bus.resp_data  <= '0;
      bus.resp_err   <= 1'b0;
      core_load_n    <= 1'b1;
      core_in        <= '0;
      core_tweak     <= '0;
      core_key       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant_vld) begin
            core_in     <= sel_in;
            core_tweak  <= sel_tweak;
            core_key    <= sel_key;
            bus.resp_id <= grant_id;
            ptr         <= ptr_nxt;
            core_load_n <= 1'b0;
          end
        end
        S_LOAD: begin
          core_load_n <= 1'b1;
          wait_cnt    <= '0;
        end
        S_WAIT: begin
          // Ready wins over expiry when both land on the same edge.
          if (core_ready) begin
            bus.resp_data  <= core_out;
            bus.resp_err   <= 1'b0;
            bus.resp_valid <= 1'b1;
          end else if (wait_expire) begin
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b1;
            bus.resp_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            op_count       <= op_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_qarma64_sched.sv
// Bench for qarma64_sched: a behavioural 17-cycle core stub and a response scoreboard.
`timescale 1ns/1ps
module tb_qarma64_sched;
  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 32;

  localparam logic [63:0]  GOLD_IN  = 64'hfb623599da6e8127;
  localparam logic [63:0]  GOLD_TW  = 64'h477d469dec0b8762;
  localparam logic [127:0] GOLD_KEY = {64'h84be85ce9804e94b, 64'hec2802d4e0a488e9};
  localparam logic [63:0]  GOLD_OUT = 64'h3ee99a6c82af0c38;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
    logic            err;
    int              lat;
  } resp_t;

  typedef struct {
    int id;
    int gap;
  } grant_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         busy;
  logic [15:0]  op_count;
  logic [63:0]  core_in, core_tweak, core_out;
  logic [127:0] core_key;
  logic         core_load_n, core_ready;

  qarma64_sched_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  qarma64_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .op_count    (op_count),
    .core_in     (core_in),
    .core_tweak  (core_tweak),
    .core_key    (core_key),
    .core_load_n (core_load_n),
    .core_out    (core_out),
    .core_ready  (core_ready)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in cipher: the published vector maps to its golden ciphertext, anything else to a keyed mix.
  function automatic logic [63:0] core_model(input logic [63:0] pt, input logic [63:0] tw,
                                             input logic [127:0] key);
    if (pt == GOLD_IN && tw == GOLD_TW && key == GOLD_KEY) return GOLD_OUT;
    return ((pt ^ tw) + key[127:64]) ^ {key[31:0], key[63:32]};
  endfunction

  // Core stub: loads on a low core_load_n edge, ready after 17 busy edges.
  logic [63:0]  stub_in = '0, stub_tw = '0, stub_out = '0;
  logic [127:0] stub_key = '0;
  logic         stub_rdy = 1'b1;
  logic         stuck = 1'b0;
  int           stub_cnt = 0;

  always @(posedge clk) begin
    if (!core_load_n) begin
      stub_in  <= core_in;
      stub_tw  <= core_tweak;
      stub_key <= core_key;
      stub_cnt <= 17;
      stub_rdy <= 1'b0;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_rdy <= 1'b1;
        stub_out <= core_model(stub_in, stub_tw, stub_key);
      end
    end
  end

  assign core_ready = stub_rdy && !stuck;
  assign core_out   = stub_out;

  resp_t  exp_q[$];
  grant_t gnt_q[$];
  int     last_grant_cyc = 0;
  int     grant_edge = 0;
  int     grant_cnt = 0;
  logic   prev_rv = 1'b0;
  int     load_low = 0;

  always @(negedge clk) begin : grant_monitor
    if (!reset && bus.req_ready != '0) begin
      grant_t g;
      grant_cnt++;
      if (gnt_q.size() == 0) begin
        check("unexpected_grant", 128'(bus.req_ready), 128'(0));
      end else begin
        g = gnt_q.pop_front();
        check("grant_onehot", 128'(bus.req_ready), 128'(1) << g.id);
        if (g.gap > 0) check("grant_gap", 128'(cyc - last_grant_cyc), 128'(g.gap));
      end
      last_grant_cyc = cyc;
      grant_edge     = cyc + 1;
    end
  end

  always @(negedge clk) begin : resp_monitor
    if (bus.resp_valid && !prev_rv) begin
      if (exp_q.size() == 0) check("unexpected_resp", 128'(bus.resp_valid), 128'(0));
      else check("resp_latency", 128'(cyc - grant_edge), 128'(exp_q[0].lat));
    end
    if (bus.resp_valid && bus.resp_ready && exp_q.size() != 0) begin
      resp_t e;
      e = exp_q.pop_front();
      check("resp_id", 128'(bus.resp_id), 128'(e.id));
      check("resp_data", 128'(bus.resp_data), 128'(e.data));
      check("resp_err", 128'(bus.resp_err), 128'(e.err));
    end
    prev_rv = bus.resp_valid;
  end

  always @(negedge clk) begin : load_monitor
    if (!core_load_n) begin
      load_low++;
    end else if (load_low != 0) begin
      check("load_n_width", 128'(load_low), 128'(1));
      load_low = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic set_req(input int i, input logic [63:0] pt, input logic [63:0] tw,
                         input logic [127:0] key);
    bus.req_in[64*i +: 64]     = pt;
    bus.req_tweak[64*i +: 64]  = tw;
    bus.req_key[128*i +: 128]  = key;
  endtask

  task automatic set_rand(input int i);
    set_req(i, {$urandom(), $urandom()}, {$urandom(), $urandom()},
            {$urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  task automatic expect_grant(input int i, input int gap);
    grant_t g;
    g.id  = i;
    g.gap = gap;
    gnt_q.push_back(g);
  endtask

  task automatic expect_op(input int i, input logic err, input int lat, input int gap);
    resp_t e;
    e.id   = ID_W'(i);
    e.data = err ? 64'h0 : core_model(bus.req_in[64*i +: 64], bus.req_tweak[64*i +: 64],
                                      bus.req_key[128*i +: 128]);
    e.err  = err;
    e.lat  = lat;
    exp_q.push_back(e);
    expect_grant(i, gap);
  endtask

  // Returns one step after the grant edge with the request withdrawn.
  task automatic wait_grant_drop(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready[i]) check("grant_wait", 128'(bus.req_ready[i]), 128'(1));
    @(posedge clk);
    #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_ops(input int target, input int budget);
    int n;
    n = 0;
    while (op_count != 16'(target) && n < budget) begin
      tick(1);
      n++;
    end
    check("op_count", 128'(op_count), 128'(target));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    int n, start;
    logic [63:0] bp_in;

    bus.req_valid  = '0;
    bus.req_in     = '0;
    bus.req_tweak  = '0;
    bus.req_key    = '0;
    bus.resp_ready = 1'b1;
    reset = 1'b1;
    tick(2);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_op_count", 128'(op_count), 128'(0));
    check("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
    check("rst_resp_id", 128'(bus.resp_id), 128'(0));
    check("rst_resp_data", 128'(bus.resp_data), 128'(0));
    check("rst_resp_err", 128'(bus.resp_err), 128'(0));
    check("rst_load_n", 128'(core_load_n), 128'(1));
    check("rst_core_in", 128'(core_in), 128'(0));
    check("rst_core_key", core_key, 128'(0));
    reset = 1'b0;
    tick(1);

    // Single op on the published vector.
    set_req(0, GOLD_IN, GOLD_TW, GOLD_KEY);
    expect_op(0, 1'b0, 19, 0);
    bus.req_valid = 4'b0001;
    wait_grant_drop(0);
    check("core_in_capture", 128'(core_in), 128'(GOLD_IN));
    check("core_tweak_capture", 128'(core_tweak), 128'(GOLD_TW));
    check("core_key_capture", core_key, GOLD_KEY);
    wait_ops(1, 60);

    // Round robin from a fresh pointer, all requesters held.
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_rand(i);
    for (int k = 0; k < 5; k++) expect_op(k % N_REQ, 1'b0, 19, (k == 0) ? 0 : 21);
    start = grant_cnt;
    bus.req_valid = '1;
    n = 0;
    while (grant_cnt < start + 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    check("rr_grant_count", 128'(grant_cnt), 128'(start + 5));
    wait_ops(5, 150);

    // Pointer wrap: after granting 2, requesters 1 and 3 -> 3 then 1.
    do_reset();
    expect_op(2, 1'b0, 19, 0);
    bus.req_valid = 4'b0100;
    wait_grant_drop(2);
    wait_ops(1, 60);
    expect_op(3, 1'b0, 19, 0);
    expect_op(1, 1'b0, 19, 21);
    bus.req_valid = 4'b1010;
    wait_grant_drop(3);
    wait_grant_drop(1);
    wait_ops(3, 80);

    // Backpressure with requester 2 waiting behind it.
    set_rand(1);
    bp_in = bus.req_in[64 +: 64];
    bus.resp_ready = 1'b0;
    expect_op(1, 1'b0, 19, 0);
    expect_op(2, 1'b0, 19, 0);
    bus.req_valid = 4'b0010;
    wait_grant_drop(1);
    bus.req_valid = 4'b0100;
    n = 0;
    while (!bus.resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_core_in_hold", 128'(core_in), 128'(bp_in));
    repeat (10) begin
      check("bp_valid", 128'(bus.resp_valid), 128'(1));
      check("bp_id", 128'(bus.resp_id), 128'(1));
      check("bp_data", 128'(bus.resp_data), 128'(exp_q[0].data));
      check("bp_busy", 128'(busy), 128'(1));
      check("bp_no_accept", 128'(bus.req_ready), 128'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    tick(1);
    check("bp_op_count", 128'(op_count), 128'(4));
    check("bp_idle", 128'(busy), 128'(0));
    check("bp_next_accept", 128'(bus.req_ready), 128'(4'b0100));
    wait_grant_drop(2);
    wait_ops(5, 60);

    // Watchdog with a core that never completes.
    stuck = 1'b1;
    expect_op(0, 1'b1, TIMEOUT + 1, 0);
    bus.req_valid = 4'b0001;
    wait_grant_drop(0);
    wait_ops(6, 80);
    stuck = 1'b0;

    // Reset five cycles into WAIT drops the op; a fresh op completes afterwards.
    set_rand(3);
    expect_grant(3, 0);
    bus.req_valid = 4'b1000;
    wait_grant_drop(3);
    tick(6);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_resp_valid", 128'(bus.resp_valid), 128'(0));
    check("mid_rst_resp_id", 128'(bus.resp_id), 128'(0));
    check("mid_rst_load_n", 128'(core_load_n), 128'(1));
    check("mid_rst_op_count", 128'(op_count), 128'(0));
    check("mid_rst_core_in", 128'(core_in), 128'(0));
    tick(2);
    reset = 1'b0;
    tick(30);
    check("post_rst_idle", 128'(busy), 128'(0));
    set_rand(1);
    expect_op(1, 1'b0, 19, 0);
    bus.req_valid = 4'b0010;
    wait_grant_drop(1);
    wait_ops(1, 60);

    tick(3);
    check("resp_queue_drained", 128'(exp_q.size()), 128'(0));
    check("grant_queue_drained", 128'(gnt_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
